controller_sequencer: RTL and testbench

- SAP-1 controller-sequencer (textbook figure 8-x family).
- Produces every control signal in the SAP-1 datapath, including S_U into the adder-subtractor, from a 6-state one-hot ring counter and the 4-bit opcode held in the instruction register's upper nibble.
- Sits between the instruction register and all datapath blocks: PC, MAR, RAM, IR, accumulator, B register, ALU, output register.

---
 rtl/sap1_pkg.sv | 34 +++
 rtl/ring_counter.sv | 31 +++
 rtl/controller_sequencer.sv | 125 ++++++++++++
 tb/tb_controller_sequencer.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sap1_pkg.sv
// Shared SAP-1 controller types: opcodes, T-state bit indices and the control word.
package sap1_pkg;

    typedef enum logic [3:0] {
        OP_LDA = 4'h0,
        OP_ADD = 4'h1,
        OP_SUB = 4'h2,
        OP_OUT = 4'hE,
        OP_HLT = 4'hF
    } opcode_e;

    localparam int unsigned T1 = 0;
    localparam int unsigned T2 = 1;
    localparam int unsigned T3 = 2;
    localparam int unsigned T4 = 3;
    localparam int unsigned T5 = 4;
    localparam int unsigned T6 = 5;

    typedef struct packed {
        logic cp;
        logic ep;
        logic lm;
        logic ce;
        logic li;
        logic ei;
        logic la;
        logic ea;
        logic su;
        logic eu;
        logic lb;
        logic lo;
    } con_word_t;

endpackage

// File: rtl/ring_counter.sv
// One-hot T-state ring: rotates left each clock, freezes on hold, returns to T1 on clear.
module ring_counter #(
    parameter int unsigned T_W = 6
) (
    input  logic           clk_i,
    input  logic           clr_i,
    input  logic           hold_i,
    output logic [T_W-1:0] t_o
);

    logic [T_W-1:0] t_q;
    logic [T_W-1:0] t_d;

    always_comb begin
        t_d = t_q;
        if (!hold_i) begin
            t_d = {t_q[T_W-2:0], t_q[T_W-1]};
        end
    end

    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            t_q <= {{(T_W-1){1'b0}}, 1'b1};
        end else begin
            t_q <= t_d;
        end
    end

    assign t_o = t_q;

endmodule

// File: rtl/controller_sequencer.sv
// SAP-1 controller-sequencer: decodes the T-state ring and IR opcode into the datapath control word.
module controller_sequencer #(
    parameter int unsigned OP_W = 4,
    parameter int unsigned T_W  = 6
) (
    input  logic            CLK,
    input  logic            CLR,
    input  logic [OP_W-1:0] OPCODE,
    output logic            CP,
    output logic            EP,
    output logic            LM,
    output logic            CE,
    output logic            LI,
    output logic            EI,
    output logic            LA,
    output logic            EA,
    output logic            S_U,
    output logic            EU,
    output logic            LB,
    output logic            LO,
    output logic            HALT,
    output logic [T_W-1:0]  T
);

    import sap1_pkg::*;

    logic      halt_q;
    logic      halt_d;
    logic      hlt_now;
    con_word_t cw;

    // HLT is recognised in T4 itself so the ring never leaves T4.
    assign hlt_now = T[T4] && (OPCODE == OP_HLT);
    assign halt_d  = halt_q | hlt_now;

    always_ff @(posedge CLK) begin
        if (CLR) begin
            halt_q <= 1'b0;
        end else begin
            halt_q <= halt_d;
        end
    end

    ring_counter #(
        .T_W(T_W)
    ) u_ring (
        .clk_i (CLK),
        .clr_i (CLR),
        .hold_i(halt_d),
        .t_o   (T)
    );

    always_comb begin
        cw = '0;
        case (1'b1)
            T[T1]: begin
                cw.ep = 1'b1;
                cw.lm = 1'b1;
            end
            T[T2]: cw.cp = 1'b1;
            T[T3]: begin
                cw.ce = 1'b1;
                cw.li = 1'b1;
            end
            T[T4]: begin
                case (OPCODE)
                    OP_LDA, OP_ADD, OP_SUB: begin
                        cw.ei = 1'b1;
                        cw.lm = 1'b1;
                        cw.su = (OPCODE == OP_SUB);
                    end
                    OP_OUT: begin
                        cw.ea = 1'b1;
                        cw.lo = 1'b1;
                    end
                    default: ;
                endcase
            end
            T[T5]: begin
                case (OPCODE)
                    OP_LDA: begin
                        cw.ce = 1'b1;
                        cw.la = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        cw.ce = 1'b1;
                        cw.lb = 1'b1;
                        cw.su = (OPCODE == OP_SUB);
                    end
                    default: ;
                endcase
            end
            T[T6]: begin
                case (OPCODE)
                    OP_ADD, OP_SUB: begin
                        cw.eu = 1'b1;
                        cw.la = 1'b1;
                        cw.su = (OPCODE == OP_SUB);
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
        // Clear and the latched halt both override whatever the decode produced.
        if (CLR || halt_q) begin
            cw = '0;
        end
    end

    assign CP   = cw.cp;
    assign EP   = cw.ep;
    assign LM   = cw.lm;
    assign CE   = cw.ce;
    assign LI   = cw.li;
    assign EI   = cw.ei;
    assign LA   = cw.la;
    assign EA   = cw.ea;
    assign S_U  = cw.su;
    assign EU   = cw.eu;
    assign LB   = cw.lb;
    assign LO   = cw.lo;
    assign HALT = !CLR && (halt_q || hlt_now);

endmodule

// File: tb/tb_controller_sequencer.sv
// Directed bench for the SAP-1 controller-sequencer with hand-computed control words.
module tb_controller_sequencer;

    logic       CLK;
    logic       CLR;
    logic [3:0] OPCODE;
    logic       CP, EP, LM, CE, LI, EI, LA, EA, S_U, EU, LB, LO, HALT;
    logic [5:0] T;

    int unsigned n_checks = 0;
    int unsigned n_fails  = 0;
    logic        mon_en   = 1'b0;

    // Control word packing: {CP,EP,LM,CE,LI,EI,LA,EA,S_U,EU,LB,LO}
    localparam logic [11:0] K_CP = 12'h800;
    localparam logic [11:0] K_EP = 12'h400;
    localparam logic [11:0] K_LM = 12'h200;
    localparam logic [11:0] K_CE = 12'h100;
    localparam logic [11:0] K_LI = 12'h080;
    localparam logic [11:0] K_EI = 12'h040;
    localparam logic [11:0] K_LA = 12'h020;
    localparam logic [11:0] K_EA = 12'h010;
    localparam logic [11:0] K_SU = 12'h008;
    localparam logic [11:0] K_EU = 12'h004;
    localparam logic [11:0] K_LB = 12'h002;
    localparam logic [11:0] K_LO = 12'h001;

    logic [11:0] ctrl;
    assign ctrl = {CP, EP, LM, CE, LI, EI, LA, EA, S_U, EU, LB, LO};

    controller_sequencer #(
        .OP_W(4),
        .T_W (6)
    ) dut (
        .CLK   (CLK),
        .CLR   (CLR),
        .OPCODE(OPCODE),
        .CP    (CP),
        .EP    (EP),
        .LM    (LM),
        .CE    (CE),
        .LI    (LI),
        .EI    (EI),
        .LA    (LA),
        .EA    (EA),
        .S_U   (S_U),
        .EU    (EU),
        .LB    (LB),
        .LO    (LO),
        .HALT  (HALT),
        .T     (T)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, n_fails=%0d", n_fails);
        $fatal(1);
    end

    // Bus-contention and load invariants, sampled mid-cycle.
    always @(negedge CLK) begin
        if (mon_en) begin
            n_checks++;
            if ($countones({EP, CE, EI, EA, EU}) > 1) begin
                n_fails++;
                $display("FAIL bus_drivers: got %b, required at most one set", {EP, CE, EI, EA, EU});
            end
            n_checks++;
            if ($countones({LA, LB, LI, LM, LO}) > 1) begin
                n_fails++;
                $display("FAIL loads: got %b, required at most one set", {LA, LB, LI, LM, LO});
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        logic [5:0] seq [6];
        seq = '{6'h02, 6'h04, 6'h08, 6'h10, 6'h20, 6'h01};
        CLR    = 1'b1;
        OPCODE = 4'h0;
        tick();
        tick();
        mon_en = 1'b1;
        n_checks++;
        if (T !== 6'h01) begin
            n_fails++;
            $display("FAIL reset_T: got %h, required 01", T);
        end
        n_checks++;
        if (ctrl !== 12'h000) begin
            n_fails++;
            $display("FAIL reset_ctrl: got %h, required 000", ctrl);
        end
        CLR = 1'b0;
        #1;
        n_checks++;
        if (HALT !== 1'b0) begin
            n_fails++;
            $display("FAIL reset_halt: got %b, required 0", HALT);
        end
        n_checks++;
        if (ctrl !== (K_EP | K_LM)) begin
            n_fails++;
            $display("FAIL reset_T1_ctrl: got %h, required %h", ctrl, K_EP | K_LM);
        end
        for (int i = 0; i < 6; i++) begin
            tick();
            n_checks++;
            if (T !== seq[i]) begin
                n_fails++;
                $display("FAIL ring_seq[%0d]: got %h, required %h", i, T, seq[i]);
            end
        end
    endtask

    task automatic test_add();
        logic [11:0] exp_c [6];
        exp_c = '{K_EP | K_LM, K_CP, K_CE | K_LI, K_EI | K_LM, K_CE | K_LB, K_EU | K_LA};
        OPCODE = 4'h1;
        #1;
        for (int s = 0; s < 6; s++) begin
            n_checks++;
            if (T !== (6'h01 << s)) begin
                n_fails++;
                $display("FAIL add_T[%0d]: got %h, required %h", s, T, 6'h01 << s);
            end
            n_checks++;
            if (ctrl !== exp_c[s] || HALT !== 1'b0) begin
                n_fails++;
                $display("FAIL add_ctrl[%0d]: got %h halt %b, required %h halt 0", s, ctrl, HALT, exp_c[s]);
            end
            tick();
        end
    endtask

    task automatic test_sub();
        logic [11:0] exp_c [6];
        logic [11:0] nxt_c [3];
        exp_c = '{K_EP | K_LM, K_CP, K_CE | K_LI,
                  K_EI | K_LM | K_SU, K_CE | K_LB | K_SU, K_EU | K_LA | K_SU};
        nxt_c = '{K_EP | K_LM, K_CP, K_CE | K_LI};
        OPCODE = 4'h2;
        #1;
        for (int s = 0; s < 6; s++) begin
            n_checks++;
            if (ctrl !== exp_c[s] || T !== (6'h01 << s)) begin
                n_fails++;
                $display("FAIL sub_ctrl[%0d]: got %h T %h, required %h T %h", s, ctrl, T, exp_c[s], 6'h01 << s);
            end
            tick();
        end
        OPCODE = 4'h0;
        #1;
        for (int s = 0; s < 3; s++) begin
            n_checks++;
            if (ctrl !== nxt_c[s]) begin
                n_fails++;
                $display("FAIL sub_next_fetch[%0d]: got %h, required %h", s, ctrl, nxt_c[s]);
            end
            tick();
        end
        repeat (3) tick();
    endtask

    task automatic test_out_hlt();
        logic [11:0] exp_c [6];
        exp_c = '{K_EP | K_LM, K_CP, K_CE | K_LI, K_EA | K_LO, 12'h000, 12'h000};
        OPCODE = 4'hE;
        #1;
        for (int s = 0; s < 6; s++) begin
            n_checks++;
            if (ctrl !== exp_c[s] || T !== (6'h01 << s)) begin
                n_fails++;
                $display("FAIL out_ctrl[%0d]: got %h T %h, required %h T %h", s, ctrl, T, exp_c[s], 6'h01 << s);
            end
            tick();
        end
        OPCODE = 4'hF;
        #1;
        for (int s = 0; s < 3; s++) begin
            n_checks++;
            if (ctrl !== exp_c[s] || HALT !== 1'b0) begin
                n_fails++;
                $display("FAIL hlt_fetch[%0d]: got %h halt %b, required %h halt 0", s, ctrl, HALT, exp_c[s]);
            end
            tick();
        end
        n_checks++;
        if (HALT !== 1'b1 || ctrl !== 12'h000 || T !== 6'h08) begin
            n_fails++;
            $display("FAIL hlt_T4: got halt %b ctrl %h T %h, required halt 1 ctrl 000 T 08", HALT, ctrl, T);
        end
        for (int i = 0; i < 10; i++) begin
            tick();
            // A changing opcode must not wake the halted machine.
            if (i == 4) begin
                OPCODE = 4'h1;
                #1;
            end
            n_checks++;
            if (HALT !== 1'b1 || ctrl !== 12'h000 || T !== 6'h08) begin
                n_fails++;
                $display("FAIL halted[%0d]: got halt %b ctrl %h T %h, required halt 1 ctrl 000 T 08", i, HALT, ctrl, T);
            end
        end
        CLR = 1'b1;
        tick();
        CLR    = 1'b0;
        OPCODE = 4'h0;
        #1;
        n_checks++;
        if (T !== 6'h01 || HALT !== 1'b0 || ctrl !== (K_EP | K_LM)) begin
            n_fails++;
            $display("FAIL hlt_clear: got T %h halt %b ctrl %h, required T 01 halt 0 ctrl %h", T, HALT, ctrl, K_EP | K_LM);
        end
    endtask

    task automatic test_clr_mid();
        logic [11:0] exp_c [3];
        exp_c = '{K_EP | K_LM, K_CP, K_CE | K_LI};
        OPCODE = 4'h0;
        repeat (4) tick();
        n_checks++;
        if (T !== 6'h10 || ctrl !== (K_CE | K_LA)) begin
            n_fails++;
            $display("FAIL lda_T5: got T %h ctrl %h, required T 10 ctrl %h", T, ctrl, K_CE | K_LA);
        end
        CLR = 1'b1;
        #1;
        n_checks++;
        if (ctrl !== 12'h000) begin
            n_fails++;
            $display("FAIL clr_mid_ctrl: got %h, required 000", ctrl);
        end
        tick();
        CLR = 1'b0;
        #1;
        for (int s = 0; s < 3; s++) begin
            n_checks++;
            if (T !== (6'h01 << s) || ctrl !== exp_c[s]) begin
                n_fails++;
                $display("FAIL clr_mid_fetch[%0d]: got T %h ctrl %h, required T %h ctrl %h", s, T, ctrl, 6'h01 << s, exp_c[s]);
            end
            tick();
        end
        repeat (3) tick();
    endtask

    task automatic test_undef();
        logic [11:0] exp_c [6];
        exp_c = '{K_EP | K_LM, K_CP, K_CE | K_LI, 12'h000, 12'h000, 12'h000};
        OPCODE = 4'h7;
        #1;
        for (int s = 0; s < 6; s++) begin
            n_checks++;
            if (T !== (6'h01 << s) || ctrl !== exp_c[s] || HALT !== 1'b0) begin
                n_fails++;
                $display("FAIL undef[%0d]: got T %h ctrl %h halt %b, required T %h ctrl %h halt 0", s, T, ctrl, HALT, 6'h01 << s, exp_c[s]);
            end
            tick();
        end
        n_checks++;
        if (T !== 6'h01) begin
            n_fails++;
            $display("FAIL undef_wrap: got %h, required 01", T);
        end
    endtask

    initial begin
        CLR    = 1'b1;
        OPCODE = 4'h0;
        test_reset();
        test_add();
        test_sub();
        test_out_hlt();
        test_clr_mid();
        test_undef();
        mon_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
